// File: rtl/cfg_regbank.sv
// Configuration register bank with per-channel stream beat counters mapped into the word space.
// Single clock, asynchronous active-low reset, one-cycle registered read port.
module cfg_regbank #(
  parameter int unsigned CFG_AWIDTH = 5,
  parameter int unsigned CFG_DWIDTH = 32,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned CNT_BASE   = 2,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned CNT_SAT    = 1
) (
  input  logic                                   axi_clk,
  input  logic                                   axi_rst_n,
  input  logic [CFG_AWIDTH-1:0]                  cfg_wr_addr,
  input  logic [CFG_DWIDTH-1:0]                  cfg_wr_data,
  input  logic                                   cfg_wr_en,
  input  logic [CFG_AWIDTH-1:0]                  cfg_rd_addr,
  input  logic                                   cfg_rd_en,
  output logic [CFG_DWIDTH-1:0]                  cfg_rd_data,
  output logic                                   cfg_rd_valid,
  output logic [CFG_DWIDTH*(2**CFG_AWIDTH)-1:0]  cfg_regs,
  output logic [(2**CFG_AWIDTH)-1:0]             cfg_strobe,
  input  logic [CHANNELS-1:0]                    mon_valid,
  input  logic [CHANNELS-1:0]                    mon_ready
);

  localparam int unsigned NWORDS = 2**CFG_AWIDTH;

  logic [CFG_DWIDTH-1:0] hold_q [NWORDS];
  logic [CNT_WIDTH-1:0]  cnt_q  [CHANNELS];
  logic [CNT_WIDTH-1:0]  cnt_d  [CHANNELS];
  logic [NWORDS-1:0]     strobe_q;
  logic [CFG_DWIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic [CFG_DWIDTH-1:0] rd_word;
  logic                  wr_is_cnt;

  always_comb begin
    wr_is_cnt = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (cfg_wr_addr == CFG_AWIDTH'(CNT_BASE + k)) wr_is_cnt = 1'b1;
    end
  end

  // A clear (write to the counter address) takes priority over a beat on the same edge.
  always_comb begin
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (cfg_wr_en && (cfg_wr_addr == CFG_AWIDTH'(CNT_BASE + k))) begin
        cnt_d[k] = '0;
      end else if (mon_valid[k] && mon_ready[k]) begin
        if (!((CNT_SAT != 0) && (&cnt_q[k]))) cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    rd_word = hold_q[cfg_rd_addr];
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (cfg_rd_addr == CFG_AWIDTH'(CNT_BASE + k)) rd_word = CFG_DWIDTH'(cnt_q[k]);
    end
  end

  // Counter-slot hold words are never written, so they stay at their reset value of 0.
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      for (int unsigned i = 0; i < NWORDS; i++) hold_q[i] <= '0;
    end else if (cfg_wr_en && !wr_is_cnt) begin
      hold_q[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      for (int unsigned k = 0; k < CHANNELS; k++) cnt_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      strobe_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      strobe_q   <= cfg_wr_en ? (NWORDS'(1) << cfg_wr_addr) : '0;
      rd_valid_q <= cfg_rd_en;
      rd_data_q  <= cfg_rd_en ? rd_word : '0;
    end
  end

  for (genvar i = 0; i < NWORDS; i++) begin : g_regs
    assign cfg_regs[i*CFG_DWIDTH +: CFG_DWIDTH] = hold_q[i];
  end

  assign cfg_strobe   = strobe_q;
  assign cfg_rd_data  = rd_data_q;
  assign cfg_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_cfg_regbank.sv
// Bench for cfg_regbank: a wide-counter instance plus two 4-bit instances (saturating, wrapping)
// share one stimulus stream and are checked every cycle against a beat-count model.
module tb_cfg_regbank;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CH = 2;
  localparam int CB = 2;
  localparam int NW = 32;

  logic            axi_clk;
  logic            axi_rst_n;
  logic [AW-1:0]   cfg_wr_addr;
  logic [DW-1:0]   cfg_wr_data;
  logic            cfg_wr_en;
  logic [AW-1:0]   cfg_rd_addr;
  logic            cfg_rd_en;
  logic [CH-1:0]   mon_valid;
  logic [CH-1:0]   mon_ready;

  logic [DW-1:0]    rd_data, s4_rd_data, w4_rd_data;
  logic             rd_valid, s4_rd_valid, w4_rd_valid;
  logic [DW*NW-1:0] regs, s4_regs, w4_regs;
  logic [NW-1:0]    strobe, s4_strobe, w4_strobe;

  cfg_regbank #(.CFG_AWIDTH(AW), .CFG_DWIDTH(DW), .CHANNELS(CH), .CNT_BASE(CB),
                .CNT_WIDTH(32), .CNT_SAT(1)) u_dut (
    .axi_clk(axi_clk), .axi_rst_n(axi_rst_n), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_wr_en(cfg_wr_en), .cfg_rd_addr(cfg_rd_addr),
    .cfg_rd_en(cfg_rd_en), .cfg_rd_data(rd_data), .cfg_rd_valid(rd_valid), .cfg_regs(regs),
    .cfg_strobe(strobe), .mon_valid(mon_valid), .mon_ready(mon_ready));

  cfg_regbank #(.CFG_AWIDTH(AW), .CFG_DWIDTH(DW), .CHANNELS(CH), .CNT_BASE(CB),
                .CNT_WIDTH(4), .CNT_SAT(1)) u_sat4 (
    .axi_clk(axi_clk), .axi_rst_n(axi_rst_n), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_wr_en(cfg_wr_en), .cfg_rd_addr(cfg_rd_addr),
    .cfg_rd_en(cfg_rd_en), .cfg_rd_data(s4_rd_data), .cfg_rd_valid(s4_rd_valid),
    .cfg_regs(s4_regs), .cfg_strobe(s4_strobe), .mon_valid(mon_valid), .mon_ready(mon_ready));

  cfg_regbank #(.CFG_AWIDTH(AW), .CFG_DWIDTH(DW), .CHANNELS(CH), .CNT_BASE(CB),
                .CNT_WIDTH(4), .CNT_SAT(0)) u_wrap4 (
    .axi_clk(axi_clk), .axi_rst_n(axi_rst_n), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_wr_en(cfg_wr_en), .cfg_rd_addr(cfg_rd_addr),
    .cfg_rd_en(cfg_rd_en), .cfg_rd_data(w4_rd_data), .cfg_rd_valid(w4_rd_valid),
    .cfg_regs(w4_regs), .cfg_strobe(w4_strobe), .mon_valid(mon_valid), .mon_ready(mon_ready));

  initial begin
    axi_clk = 1'b0;
    forever #5 axi_clk = ~axi_clk;
  end

  int checks = 0;
  int errors = 0;
  int strobe5_n = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit is_cnt_addr(input logic [AW-1:0] a);
    return (int'(a) >= CB) && (int'(a) < CB + CH);
  endfunction

  // What a counter of width w shows after b beats since its last clear.
  function automatic logic [31:0] cnt_view(input int b, input int w, input bit sat);
    longint mx;
    if (w >= 32) return 32'(b);
    mx = (longint'(1) << w) - 1;
    if (sat) return (longint'(b) > mx) ? 32'(mx) : 32'(b);
    return 32'(longint'(b) & mx);
  endfunction

  // Model state: hold words, beats since last clear, and the pending read / strobe outputs.
  logic [31:0] m_regs [NW];
  int          m_beats [CH];
  logic        m_rd_valid;
  logic        m_rd_is_cnt;
  int          m_rd_beats;
  logic [31:0] m_rd_hold;
  logic [31:0] m_strobe;

  always @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      for (int i = 0; i < NW; i++) m_regs[i] <= '0;
      for (int k = 0; k < CH; k++) m_beats[k] <= 0;
      m_rd_valid  <= 1'b0;
      m_rd_is_cnt <= 1'b0;
      m_rd_beats  <= 0;
      m_rd_hold   <= '0;
      m_strobe    <= '0;
    end else begin
      m_rd_valid  <= cfg_rd_en;
      m_rd_is_cnt <= cfg_rd_en && is_cnt_addr(cfg_rd_addr);
      m_rd_beats  <= (cfg_rd_en && is_cnt_addr(cfg_rd_addr)) ? m_beats[int'(cfg_rd_addr) - CB] : 0;
      m_rd_hold   <= (cfg_rd_en && !is_cnt_addr(cfg_rd_addr)) ? m_regs[cfg_rd_addr] : '0;
      m_strobe    <= cfg_wr_en ? (32'h1 << cfg_wr_addr) : '0;
      for (int k = 0; k < CH; k++) begin
        if (cfg_wr_en && int'(cfg_wr_addr) == CB + k) m_beats[k] <= 0;
        else if (mon_valid[k] && mon_ready[k]) m_beats[k] <= m_beats[k] + 1;
      end
      if (cfg_wr_en && !is_cnt_addr(cfg_wr_addr)) m_regs[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  always @(negedge axi_clk) begin
    if (chk_en) begin
      check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      check("s4_rd_valid", 32'(s4_rd_valid), 32'(m_rd_valid));
      check("w4_rd_valid", 32'(w4_rd_valid), 32'(m_rd_valid));
      check("rd_data", rd_data, !m_rd_valid ? 32'h0 :
            m_rd_is_cnt ? cnt_view(m_rd_beats, 32, 1'b1) : m_rd_hold);
      check("s4_rd_data", s4_rd_data, !m_rd_valid ? 32'h0 :
            m_rd_is_cnt ? cnt_view(m_rd_beats, 4, 1'b1) : m_rd_hold);
      check("w4_rd_data", w4_rd_data, !m_rd_valid ? 32'h0 :
            m_rd_is_cnt ? cnt_view(m_rd_beats, 4, 1'b0) : m_rd_hold);
      check("strobe", strobe, m_strobe);
      for (int i = 0; i < NW; i++) begin
        check($sformatf("regs[%0d]", i), regs[i*DW +: DW], m_regs[i]);
      end
    end
    if (strobe[5]) strobe5_n++;
  end

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  logic [9:0] rdy_pat;

  initial begin
    axi_rst_n   = 1'b0;
    cfg_wr_addr = '0;
    cfg_wr_data = '0;
    cfg_wr_en   = 1'b0;
    cfg_rd_addr = '0;
    cfg_rd_en   = 1'b0;
    mon_valid   = '0;
    mon_ready   = '0;
    rdy_pat     = 10'b1011011001;
    tick();
    tick();
    check("reset_regs_any", 32'(|regs), 32'h0);
    check("reset_strobe", strobe, 32'h0);
    check("reset_rd_valid", 32'(rd_valid), 32'h0);
    chk_en    = 1'b1;
    axi_rst_n = 1'b1;

    // Plain write then read of a hold word.
    strobe5_n   = 0;
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 5'd5;
    cfg_wr_data = 32'hDEADBEEF;
    tick();
    check("wr5_word", regs[5*DW +: DW], 32'hDEADBEEF);
    check("wr5_strobe", strobe, 32'h0000_0020);
    cfg_wr_en   = 1'b0;
    cfg_rd_en   = 1'b1;
    cfg_rd_addr = 5'd5;
    tick();
    check("rd5_valid", 32'(rd_valid), 32'h1);
    check("rd5_data", rd_data, 32'hDEADBEEF);
    cfg_rd_en = 1'b0;
    tick();
    check("idle_rd_data", rd_data, 32'h0);
    check("idle_rd_valid", 32'(rd_valid), 32'h0);
    tick();
    check("strobe5_pulses", 32'(strobe5_n), 32'd1);

    // Channel 0: valid for 10 cycles, ready on 6 of them.
    for (int i = 0; i < 10; i++) begin
      mon_valid = 2'b01;
      mon_ready = {1'b0, rdy_pat[9-i]};
      tick();
    end
    mon_valid   = '0;
    mon_ready   = '0;
    cfg_rd_en   = 1'b1;
    cfg_rd_addr = 5'(CB);
    tick();
    check("ch0_count", rd_data, 32'd6);
    check("ch0_count_s4", s4_rd_data, 32'd6);

    // Channel 1: 20 beats into 32-bit, 4-bit saturating and 4-bit wrapping counters.
    cfg_rd_en = 1'b0;
    mon_valid = 2'b10;
    mon_ready = 2'b10;
    repeat (20) tick();
    mon_valid   = '0;
    mon_ready   = '0;
    cfg_rd_en   = 1'b1;
    cfg_rd_addr = 5'(CB + 1);
    tick();
    check("ch1_count32", rd_data, 32'd20);
    check("ch1_sat4", s4_rd_data, 32'd15);
    check("ch1_wrap4", w4_rd_data, 32'd4);

    // Clear colliding with a beat, with a same-edge read of the pre-edge value.
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 5'(CB + 1);
    cfg_wr_data = 32'hFFFF_FFFF;
    mon_valid   = 2'b10;
    mon_ready   = 2'b10;
    tick();
    check("clr_pre_read", rd_data, 32'd20);
    check("clr_pre_read_w4", w4_rd_data, 32'd4);
    check("clr_strobe", strobe, 32'h0000_0008);
    cfg_wr_en = 1'b0;
    mon_valid = '0;
    mon_ready = '0;
    tick();
    check("clr_count", rd_data, 32'd0);
    check("clr_count_s4", s4_rd_data, 32'd0);
    check("clr_hold_word", regs[(CB+1)*DW +: DW], 32'h0);

    // Same-edge read and write of a hold word returns the old value.
    cfg_rd_en   = 1'b0;
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 5'd7;
    cfg_wr_data = 32'h1111_1111;
    tick();
    cfg_wr_data = 32'h2222_2222;
    cfg_rd_en   = 1'b1;
    cfg_rd_addr = 5'd7;
    tick();
    check("raw_old", rd_data, 32'h1111_1111);
    check("raw_new_word", regs[7*DW +: DW], 32'h2222_2222);

    // Load counters and a pending read/strobe, then reset asynchronously mid-cycle.
    cfg_wr_addr = 5'd9;
    cfg_wr_data = 32'h0000_0005;
    cfg_rd_addr = 5'd5;
    mon_valid   = 2'b11;
    mon_ready   = 2'b11;
    repeat (3) tick();
    mon_valid = '0;
    mon_ready = '0;
    cfg_wr_en = 1'b0;
    #3;
    axi_rst_n = 1'b0;
    #1;
    check("async_rst_regs_any", 32'(|regs), 32'h0);
    check("async_rst_strobe", strobe, 32'h0);
    check("async_rst_rd_data", rd_data, 32'h0);
    check("async_rst_rd_valid", 32'(rd_valid), 32'h0);
    tick();
    check("rst_read_no_valid", 32'(rd_valid), 32'h0);
    axi_rst_n   = 1'b1;
    cfg_rd_addr = 5'(CB);
    tick();
    check("post_rst_ch0", rd_data, 32'd0);
    check("post_rst_valid", 32'(rd_valid), 32'h1);
    cfg_rd_addr = 5'(CB + 1);
    tick();
    check("post_rst_ch1", rd_data, 32'd0);
    cfg_rd_en = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
